// File: rtl/dense_layer_sequencer_pkg.sv
// rtl/dense_layer_sequencer_pkg.sv - shared FSM state type and sizing helpers for the dense layer sequencer
package dense_layer_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        MAC   = 2'd2,
        EMIT  = 2'd3
    } state_t;

    // Index width, never less than one bit so single-entry ranges still have a port.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Smallest accumulator that holds NUM_INPUTS full-scale 17-bit products without wrapping.
    function automatic int min_acc_width(input int n);
        return 17 + ((n > 1) ? $clog2(n) : 0);
    endfunction

endpackage

// File: rtl/dense_mac.sv
// rtl/dense_mac.sv - signed-weight x unsigned-activation multiply-accumulate stage
module dense_mac #(
    parameter int ACC_WIDTH = 26
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        enable,
    input  logic signed [7:0]           weight,
    input  logic        [7:0]           act,
    output logic signed [ACC_WIDTH-1:0] acc,
    output logic signed [ACC_WIDTH-1:0] acc_next
);

    logic signed [16:0] weight_ext;
    logic signed [16:0] act_ext;
    logic signed [16:0] product;

    assign weight_ext = {{9{weight[7]}}, weight};
    assign act_ext    = {9'b0, act};
    assign product    = weight_ext * act_ext;
    // acc_next exposes the sum including the current term so the final product can be captured on the same edge.
    assign acc_next   = acc + ACC_WIDTH'(product);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/dense_layer_sequencer.sv
// rtl/dense_layer_sequencer.sv - walks every neuron of a dense layer through fetch, MAC and handshaked emit
module dense_layer_sequencer
    import dense_layer_sequencer_pkg::*;
#(
    parameter int NUM_NEURONS = 30,
    parameter int NUM_INPUTS  = 432,
    parameter int ACC_WIDTH   = 26,
    parameter int OUT_SHIFT   = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [NUM_INPUTS*8-1:0]              act_flat,
    output logic [idx_width(NUM_NEURONS)-1:0]    neuron_index,
    input  logic [NUM_INPUTS*8-1:0]              neuron_weights_flat,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [idx_width(NUM_NEURONS)-1:0]    out_index,
    output logic signed [ACC_WIDTH-1:0]          out_acc,
    output logic [7:0]                           out_act,
    output logic                                 busy,
    output logic                                 done
);

    localparam int IW = idx_width(NUM_NEURONS);
    localparam int CW = idx_width(NUM_INPUTS);
    localparam logic [IW-1:0] LAST_NEURON = IW'(NUM_NEURONS - 1);
    localparam logic [CW-1:0] LAST_INPUT  = CW'(NUM_INPUTS - 1);
    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(255);

    state_t                        state;
    logic [CW-1:0]                 in_cnt;
    logic signed [7:0]             cur_weight;
    logic [7:0]                    cur_act;
    logic signed [ACC_WIDTH-1:0]   acc;
    logic signed [ACC_WIDTH-1:0]   acc_next;

    assign cur_weight = $signed(neuron_weights_flat[{in_cnt, 3'b000} +: 8]);
    assign cur_act    = act_flat[{in_cnt, 3'b000} +: 8];

    dense_mac #(
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (state == FETCH),
        .enable   (state == MAC),
        .weight   (cur_weight),
        .act      (cur_act),
        .acc      (acc),
        .acc_next (acc_next)
    );

    function automatic logic [7:0] saturate(input logic signed [ACC_WIDTH-1:0] value);
        logic signed [ACC_WIDTH-1:0] shifted;
        shifted = value >>> OUT_SHIFT;
        if (shifted[ACC_WIDTH-1]) begin
            return 8'h00;
        end else if (shifted > SAT_MAX) begin
            return 8'hFF;
        end else begin
            return shifted[7:0];
        end
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            neuron_index <= '0;
            in_cnt       <= '0;
            out_valid    <= 1'b0;
            out_index    <= '0;
            out_acc      <= '0;
            out_act      <= 8'h00;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= FETCH;
                        neuron_index <= '0;
                        in_cnt       <= '0;
                        busy         <= 1'b1;
                    end
                end
                FETCH: begin
                    in_cnt <= '0;
                    state  <= MAC;
                end
                MAC: begin
                    if (in_cnt == LAST_INPUT) begin
                        in_cnt    <= '0;
                        state     <= EMIT;
                        out_valid <= 1'b1;
                        out_acc   <= acc_next;
                        out_act   <= saturate(acc_next);
                        out_index <= neuron_index;
                    end else begin
                        in_cnt <= in_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (neuron_index == LAST_NEURON) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            neuron_index <= neuron_index + 1'b1;
                            in_cnt       <= '0;
                            state        <= FETCH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dense_layer_sequencer.sv
// tb/tb_dense_layer_sequencer.sv - bench for dense_layer_sequencer with ROM model and arithmetic reference
module tb_dense_layer_sequencer;

    localparam int NN = 2;
    localparam int NI = 4;
    localparam int AW = 20;
    localparam int NV = 10;

    typedef struct {
        logic [NN-1:0][NI-1:0][7:0] w;
        logic [NI-1:0][7:0]         a;
        int                         acc0;
        int                         act0;
        int                         acc1;
        int                         act1;
    } vec_t;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [NI*8-1:0]          act_flat = '0;
    logic [0:0]               neuron_index;
    logic [NI*8-1:0]          rom_q = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b1;
    logic [0:0]               out_index;
    logic signed [AW-1:0]     out_acc;
    logic [7:0]               out_act;
    logic                     busy;
    logic                     done;
    logic [NN-1:0][NI-1:0][7:0] wmem = '0;

    logic                     big_start = 1'b0;
    logic [432*8-1:0]         big_act = {432{8'hFF}};
    logic [432*8-1:0]         big_w = {432{8'h80}};
    logic [4:0]               big_nidx;
    logic                     big_valid;
    logic [4:0]               big_oidx;
    logic signed [25:0]       big_acc;
    logic [7:0]               big_oact;
    logic                     big_busy;
    logic                     big_done;

    int tests = 0;
    int failed = 0;
    int accept_cnt = 0;
    int done_cnt = 0;
    vec_t tbl[NV];

    dense_layer_sequencer #(
        .NUM_NEURONS(NN), .NUM_INPUTS(NI), .ACC_WIDTH(AW), .OUT_SHIFT(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .act_flat(act_flat),
        .neuron_index(neuron_index), .neuron_weights_flat(rom_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_index(out_index),
        .out_acc(out_acc), .out_act(out_act), .busy(busy), .done(done)
    );

    dense_layer_sequencer u_big (
        .clk(clk), .rst_n(rst_n), .start(big_start), .act_flat(big_act),
        .neuron_index(big_nidx), .neuron_weights_flat(big_w),
        .out_valid(big_valid), .out_ready(1'b0), .out_index(big_oidx),
        .out_acc(big_acc), .out_act(big_oact), .busy(big_busy), .done(big_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_q <= wmem[neuron_index];

    always @(posedge clk) begin
        if (out_valid && out_ready) accept_cnt++;
        if (done) done_cnt++;
    end

    function automatic int ref_acc(input logic [NI-1:0][7:0] w, input logic [NI-1:0][7:0] a);
        int s = 0;
        for (int i = 0; i < NI; i++) s += int'($signed(w[i])) * int'(a[i]);
        return s;
    endfunction

    function automatic int ref_act(input int acc);
        int s = acc >>> 0;
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
    endfunction

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check("valid_timeout", 0, 1);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int k);
        bit ok;
        wmem = v.w;
        act_flat = v.a;
        out_ready = 1'b1;
        pulse_start();
        for (int n = 0; n < NN; n++) begin
            wait_valid(ok);
            if (ok) begin
                check($sformatf("v%0d_n%0d_index", k, n), int'(out_index), n);
                check($sformatf("v%0d_n%0d_acc", k, n), int'(out_acc), n == 0 ? v.acc0 : v.acc1);
                check($sformatf("v%0d_n%0d_act", k, n), int'(out_act), n == 0 ? v.act0 : v.act1);
            end
            @(negedge clk);
        end
        check($sformatf("v%0d_done", k), int'(done), 1);
        @(negedge clk);
    endtask

    initial begin
        bit ok;
        bit vh[14];
        bit dh[14];
        int acc0, dn0;

        tbl[0].w[0] = {8'd4, 8'd3, 8'd2, 8'd1};
        tbl[0].w[1] = {4{8'hFF}};
        tbl[0].a    = {8'd40, 8'd30, 8'd20, 8'd10};
        tbl[0].acc0 = 300;  tbl[0].act0 = 255; tbl[0].acc1 = -100; tbl[0].act1 = 0;
        tbl[1].w[0] = {8'd0, 8'd0, 8'd0, 8'd1};
        tbl[1].w[1] = {8'd0, 8'd0, 8'd1, 8'd1};
        tbl[1].a    = {8'd0, 8'd0, 8'd1, 8'd255};
        tbl[1].acc0 = 255;  tbl[1].act0 = 255; tbl[1].acc1 = 256;  tbl[1].act1 = 255;
        tbl[2].w[0] = '0;
        tbl[2].w[1] = {8'd0, 8'd0, 8'd1, 8'hFF};
        tbl[2].a    = {8'd0, 8'd0, 8'd1, 8'd255};
        tbl[2].acc0 = 0;    tbl[2].act0 = 0;   tbl[2].acc1 = -254; tbl[2].act1 = 0;
        tbl[3].w[0] = {8'd0, 8'd0, 8'd1, 8'd1};
        tbl[3].w[1] = {4{8'h80}};
        tbl[3].a    = {8'd1, 8'd1, 8'd50, 8'd100};
        tbl[3].acc0 = 150;  tbl[3].act0 = 150; tbl[3].acc1 = -19456; tbl[3].act1 = 0;
        for (int k = 4; k < NV; k++) begin
            tbl[k].w[0] = $urandom;
            tbl[k].w[1] = $urandom;
            tbl[k].a    = $urandom;
            if (k == 4) tbl[k].w[1] = {4{8'h80}};
            if (k == 4) tbl[k].a = {4{8'hFF}};
            if (k == 5) tbl[k].w[0] = {4{8'h7F}};
            tbl[k].acc0 = ref_acc(tbl[k].w[0], tbl[k].a);
            tbl[k].act0 = ref_act(tbl[k].acc0);
            tbl[k].acc1 = ref_acc(tbl[k].w[1], tbl[k].a);
            tbl[k].act1 = ref_act(tbl[k].acc1);
        end

        #12;
        check("rst_valid", int'(out_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_acc", int'(out_acc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("idle_valid", int'(out_valid), 0);
        check("idle_index", int'(neuron_index), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);

        for (int k = 0; k < NV; k++) run_vec(tbl[k], k);

        // Edge-accurate latency: the start-sampling edge is edge 0.
        wmem = tbl[0].w;
        act_flat = tbl[0].a;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int e = 1; e < 14; e++) begin
            @(posedge clk);
            @(negedge clk);
            vh[e] = out_valid;
            dh[e] = done;
        end
        check("lat_valid_e4", int'(vh[4]), 0);
        check("lat_valid_e5", int'(vh[5]), 1);
        check("lat_valid_e10", int'(vh[10]), 0);
        check("lat_valid_e11", int'(vh[11]), 1);
        check("lat_done_e11", int'(dh[11]), 0);
        check("lat_done_e12", int'(dh[12]), 1);
        check("lat_done_e13", int'(dh[13]), 0);
        @(negedge clk);

        // Backpressure: five stalled cycles in EMIT.
        wmem = tbl[3].w;
        act_flat = tbl[3].a;
        out_ready = 1'b0;
        pulse_start();
        wait_valid(ok);
        for (int c = 0; c < 5; c++) begin
            check("bp_valid", int'(out_valid), 1);
            check("bp_acc", int'(out_acc), tbl[3].acc0);
            check("bp_act", int'(out_act), tbl[3].act0);
            check("bp_index", int'(out_index), 0);
            check("bp_nidx", int'(neuron_index), 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release", int'(out_valid), 0);
        wait_valid(ok);
        check("bp_n1_acc", int'(out_acc), tbl[3].acc1);
        check("bp_n1_index", int'(out_index), 1);
        @(negedge clk);
        check("bp_done", int'(done), 1);
        @(negedge clk);

        // Asynchronous reset in the middle of neuron 1.
        wmem = tbl[0].w;
        act_flat = tbl[0].a;
        pulse_start();
        wait_valid(ok);
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("ar_valid", int'(out_valid), 0);
        check("ar_nidx", int'(neuron_index), 0);
        check("ar_acc", int'(out_acc), 0);
        check("ar_act", int'(out_act), 0);
        check("ar_busy", int'(busy), 0);
        check("ar_mac_acc", int'(dut.acc), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("ar_idle", int'(out_valid) + int'(busy), 0);
        run_vec(tbl[0], 100);

        // Start pulsed mid-MAC is ignored.
        acc0 = accept_cnt;
        dn0 = done_cnt;
        pulse_start();
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        check("ign_results", accept_cnt - acc0, 2);
        check("ign_done", done_cnt - dn0, 1);
        check("ign_busy", int'(busy), 0);

        // Default-sized instance: full-scale negative sum must not wrap.
        @(negedge clk);
        big_start = 1'b1;
        @(negedge clk);
        big_start = 1'b0;
        ok = 1'b0;
        for (int c = 0; c < 600; c++) begin
            if (big_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("big_valid", int'(ok), 1);
        check("big_acc", int'(big_acc), -14100480);
        check("big_act", int'(big_oact), 0);
        check("big_index", int'(big_oidx) + int'(big_nidx), 0);
        check("big_busy", int'(big_busy) - int'(big_done), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/dense_layer_sequencer.md
DENSE_LAYER_SEQUENCER -- requirements
Module: dense_layer_sequencer

Interface
REQ-001 SHALL have parameter NUM_NEURONS, default 30, neurons per layer.
REQ-002 SHALL have parameter NUM_INPUTS, default 432, inputs per neuron.
REQ-003 SHALL have parameter ACC_WIDTH, default 26, signed accumulator width; must be >= 17+clog2(NUM_INPUTS).
REQ-004 SHALL have parameter OUT_SHIFT, default 8, arithmetic right shift applied before output saturation.
REQ-005 clk  in  1  single clock; all logic on rising edge.
REQ-006 rst_n  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  one-cycle request to process the whole layer.
REQ-008 act_flat  in  NUM_INPUTS*8  unsigned 8-bit activations, element i at [8i+:8]; held stable while busy.
REQ-009 neuron_index  out  clog2(NUM_NEURONS)  registered index driven to the weight ROM.
REQ-010 neuron_weights_flat  in  NUM_INPUTS*8  signed weights from ROM, one-cycle registered latency after neuron_index.
REQ-011 out_valid  out  1  result valid; held until accepted.
REQ-012 out_ready  in  1  consumer accepts result when high with out_valid.
REQ-013 out_index  out  clog2(NUM_NEURONS)  neuron number of current result.
REQ-014 out_acc  out  ACC_WIDTH  signed dot product.
REQ-015 out_act  out  8  unsigned ReLU/saturated activation.
REQ-016 busy  out  1  high from FETCH through final EMIT.
REQ-017 done  out  1  one-cycle pulse after last result accepted.

Function
REQ-018 FSM SHALL have states IDLE, FETCH, MAC, EMIT.
- IDLE: start=1 -> FETCH with neuron_index=0; else stay.
- FETCH (1 cycle): accumulator and input counter cleared; -> MAC.
- MAC (NUM_INPUTS cycles): cycle j adds sext(w[j]) * zext(act[j]) (17-bit signed product, sign-extended to ACC_WIDTH); after term NUM_INPUTS-1 -> EMIT with out_acc/out_act/out_index registered, out_valid=1.
- EMIT: hold until out_valid&&out_ready; then if neuron_index==NUM_NEURONS-1 -> IDLE with done=1 for one cycle, else neuron_index+1 -> FETCH.
REQ-019 out_valid SHALL first assert in the cycle following the (NUM_INPUTS+1)th edge after the start-sampling edge; with out_ready=1 each neuron takes NUM_INPUTS+2 cycles.
REQ-020 out_act SHALL be 0 if (out_acc>>>OUT_SHIFT)<0, 255 if >255, else low 8 bits.
REQ-021 Accumulator SHALL never wrap given REQ-003 sizing.
REQ-022 start while busy SHALL be ignored; start in the IDLE cycle carrying done SHALL be accepted.
REQ-023 neuron_index, out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-024 Input counter SHALL wrap to 0 on entry to FETCH; neuron_index SHALL not exceed NUM_NEURONS-1.

Reset
REQ-025 rst_n=0 SHALL force IDLE immediately, regardless of state, and clear neuron_index, out_valid, out_index, out_acc, out_act, busy, done and accumulator to 0.
REQ-026 After reset release, no output SHALL change until start is sampled.

Structure
REQ-027 Shared package SHALL hold the FSM state enum and a width function (clog2-based) for index and accumulator sizing.
REQ-028 Multiply-accumulate SHALL be a sub-module dense_mac (clear, enable, 8-bit signed weight, 8-bit unsigned activation, ACC_WIDTH accumulator).

Verification (bench models ROM with 1-cycle latency; NUM_NEURONS=2, NUM_INPUTS=4, OUT_SHIFT=0 unless stated)
REQ-029 w0={1,2,3,4}, w1={-1,-1,-1,-1}, act={10,20,30,40}, start -> (idx0, acc 300, act 255) then (idx1, acc -100, act 0), done once.
REQ-030 Defaults, all w=-128, all act=255 -> out_acc=-14100480, out_act=0, no wrap.
REQ-031 start at edge 0, out_ready=1 -> out_valid first high after edge 5, second result after edge 11, done after edge 12.
REQ-032 out_ready low 5 cycles in EMIT -> out_valid, out_* and neuron_index unchanged; proceeds on first ready.
REQ-033 rst_n pulsed low during MAC of neuron 1 -> all outputs 0 asynchronously, IDLE; new start yields REQ-029 results.
REQ-034 start pulsed during MAC -> ignored, exactly two results and one done.
